// File: rtl/diff_freq_serial_in_pkg.sv
// Shared definitions for the differential-frequency serial capture path.
//   state_e          : capture FSM state encoding
//   DEF_*_PERIOD     : reset defaults of the latched bit periods
//   CMD_*            : command codes used by the host-side checker
//   eff_period()     : maps a programmed period of 0 onto 1
package diff_freq_serial_in_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEF_SLOW_PERIOD = 8'd20;
    localparam logic [7:0] DEF_FAST_PERIOD = 8'd5;

    localparam logic [7:0] CMD_FREQ = 8'h0A;
    localparam logic [7:0] CMD_DATA = 8'h0B;

    // A zero period would never reach its end tick; run it as one cycle.
    function automatic logic [7:0] eff_period(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage

// File: rtl/diff_freq_bit_timer.sv
// Per-bit timer for the serial capture path.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   en_i            : count while high; counter is held at 0 otherwise
//   fast_sel_i      : 1 = current bit uses the fast period, 0 = slow
//   slow_period_i   : latched slow period (cycles)
//   fast_period_i   : latched fast period (cycles)
//   mid_tick_o      : strobe at tick (P-1)>>1, the sample point
//   end_tick_o      : strobe at tick P-1, the last cycle of the bit
module diff_freq_bit_timer
    import diff_freq_serial_in_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       fast_sel_i,
    input  logic [7:0] slow_period_i,
    input  logic [7:0] fast_period_i,
    output logic       mid_tick_o,
    output logic       end_tick_o
);

    logic [7:0] tick_cnt_q;
    logic [7:0] tick_cnt_d;
    logic [7:0] period;
    logic [7:0] last_tick;

    always_comb begin
        period     = eff_period(fast_sel_i ? fast_period_i : slow_period_i);
        last_tick  = period - 8'd1;
        mid_tick_o = en_i && (tick_cnt_q == (last_tick >> 1));
        end_tick_o = en_i && (tick_cnt_q == last_tick);
        // Wraps to 0 at the end of each bit, so the next bit starts clean.
        tick_cnt_d = 8'd0;
        if (en_i && !end_tick_o) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/diff_freq_serial_in.sv
// Capture side of the differential-frequency serial channel. Each bit of a
// DATA_BIT-bit word (LSB first) is held for the slow or fast period chosen by
// the latched frequency pattern; the word is rebuilt from mid-bit samples.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : start a frame (bit 0 begins next cycle); ignored if busy
//   stop_i          : request idle after the current word completes
//   mode_i          : 0 = one-shot, 1 = repeat (latched with start_i)
//   serial_i        : serial line, idle low
//   freq_pattern_i  : per-bit period select (1 = fast)
//   slow_period_i   : slow bit period, cycles
//   fast_period_i   : fast bit period, cycles
//   data_o          : last completed word
//   bit_tick_o      : pulse per sampled bit
//   done_tick_o     : pulse when data_o updates
//   busy_o          : frame bits in progress
//   err_o           : sticky mid/end sample mismatch, cleared by start_i
module diff_freq_serial_in
    import diff_freq_serial_in_pkg::*;
#(
    parameter int         DATA_BIT    = 32,
    parameter logic [7:0] SLOW_PERIOD = DEF_SLOW_PERIOD,
    parameter logic [7:0] FAST_PERIOD = DEF_FAST_PERIOD
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                mode_i,
    input  logic                serial_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    output logic [DATA_BIT-1:0] data_o,
    output logic                bit_tick_o,
    output logic                done_tick_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int BW = $clog2(DATA_BIT);

    state_e              state_q,     state_d;
    logic                mode_q,      mode_d;
    logic [DATA_BIT-1:0] freq_q,      freq_d;
    logic [7:0]          slow_q,      slow_d;
    logic [7:0]          fast_q,      fast_d;
    logic [BW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_BIT-1:0] shift_q,     shift_d;
    logic [DATA_BIT-1:0] data_q,      data_d;
    logic                bit_tick_q,  bit_tick_d;
    logic                done_tick_q, done_tick_d;
    logic                err_q,       err_d;
    logic                stop_req_q,  stop_req_d;

    logic mid_tick;
    logic end_tick;
    logic mid_val;

    diff_freq_bit_timer u_bit_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (state_q == S_DATA),
        .fast_sel_i    (freq_q[bit_cnt_q]),
        .slow_period_i (slow_q),
        .fast_period_i (fast_q),
        .mid_tick_o    (mid_tick),
        .end_tick_o    (end_tick)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        freq_d      = freq_q;
        slow_d      = slow_q;
        fast_d      = fast_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        bit_tick_d  = 1'b0;
        done_tick_d = 1'b0;
        err_d       = err_q;
        stop_req_d  = stop_req_q | stop_i;

        // When P = 1 the mid sample is taken in the end cycle itself, so the
        // end check must compare against the live line, not the stale bit.
        mid_val = mid_tick ? serial_i : shift_q[bit_cnt_q];

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    freq_d     = freq_pattern_i;
                    slow_d     = slow_period_i;
                    fast_d     = fast_period_i;
                    bit_cnt_d  = '0;
                    err_d      = 1'b0;
                    stop_req_d = 1'b0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (mid_tick) begin
                    shift_d[bit_cnt_q] = serial_i;
                    bit_tick_d         = 1'b1;
                end
                if (end_tick) begin
                    if (serial_i != mid_val) begin
                        err_d = 1'b1;
                    end
                    if (bit_cnt_q == BW'(DATA_BIT - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_DONE: begin
                data_d      = shift_q;
                done_tick_d = 1'b1;
                // A stop arriving in this very cycle still ends the run.
                if (mode_q && !stop_req_d) begin
                    freq_d    = freq_pattern_i;
                    slow_d    = slow_period_i;
                    fast_d    = fast_period_i;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            freq_q      <= '0;
            slow_q      <= SLOW_PERIOD;
            fast_q      <= FAST_PERIOD;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            bit_tick_q  <= 1'b0;
            done_tick_q <= 1'b0;
            err_q       <= 1'b0;
            stop_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            freq_q      <= freq_d;
            slow_q      <= slow_d;
            fast_q      <= fast_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            bit_tick_q  <= bit_tick_d;
            done_tick_q <= done_tick_d;
            err_q       <= err_d;
            stop_req_q  <= stop_req_d;
        end
    end

    assign data_o      = data_q;
    assign bit_tick_o  = bit_tick_q;
    assign done_tick_o = done_tick_q;
    assign busy_o      = (state_q == S_DATA);
    assign err_o       = err_q;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Scoreboard bench for diff_freq_serial_in: stimulus pushes the expected word,
// done cycle and err_o level; a negedge monitor pops on every done_tick_o.
module tb_diff_freq_serial_in;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          serial_i = 1'b0;
    logic [DW-1:0] freq_pattern_i = '0;
    logic [7:0]    slow_period_i = 8'd20;
    logic [7:0]    fast_period_i = 8'd5;
    logic [DW-1:0] data_o;
    logic          bit_tick_o;
    logic          done_tick_o;
    logic          busy_o;
    logic          err_o;

    diff_freq_serial_in #(.DATA_BIT(DW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .mode_i         (mode_i),
        .serial_i       (serial_i),
        .freq_pattern_i (freq_pattern_i),
        .slow_period_i  (slow_period_i),
        .fast_period_i  (fast_period_i),
        .data_o         (data_o),
        .bit_tick_o     (bit_tick_o),
        .done_tick_o    (done_tick_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   btick = 0;
    int   start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every done_tick_o is matched against the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bit_tick_o) btick++;
            if (done_tick_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_tick_o at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("data_o", data_o, mon_e.data);
                    check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("err_o_at_done", {31'd0, err_o}, {31'd0, mon_e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int eff(input logic [7:0] p);
        return (p == 8'd0) ? 1 : int'(p);
    endfunction

    task automatic do_start(input logic mode, input logic [DW-1:0] freq,
                            input logic [7:0] slow, input logic [7:0] fast);
        mode_i         = mode;
        freq_pattern_i = freq;
        slow_period_i  = slow;
        fast_period_i  = fast;
        start_i        = 1'b1;
        start_cyc      = cyc;
        step();
        start_i        = 1'b0;
    endtask

    // Model of the output channel: bit i held for its period, optionally
    // inverted during the last cycle of bit glitch_bit.
    task automatic drive_frame(input logic [DW-1:0] word, input logic [DW-1:0] freq,
                               input logic [7:0] slow, input logic [7:0] fast,
                               input int glitch_bit);
        for (int i = 0; i < DW; i++) begin
            int p = freq[i] ? eff(fast) : eff(slow);
            for (int t = 0; t < p; t++) begin
                serial_i = (i == glitch_bit && t == p - 1) ? ~word[i] : word[i];
                step();
            end
        end
        serial_i = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 100 && (sb.size() != 0 || busy_o); k++) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_data_o", data_o, 32'd0);
        check("rst_flags", {27'd0, bit_tick_o, done_tick_o, busy_o, err_o, 1'b0}, 32'd0);
        rst_ni = 1'b1;
        step();

        // 1: all fast, P = 5
        btick = 0;
        do_start(1'b0, 32'hFFFF_FFFF, 8'd20, 8'd5);
        sb.push_back('{32'hA5A5_5A5A, start_cyc + 162, 1'b0});
        drive_frame(32'hA5A5_5A5A, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
        wait_quiet();
        check("t1_bit_ticks", 32'(btick), 32'd32);

        // 2: mixed periods
        do_start(1'b0, 32'h0000_FFFF, 8'd20, 8'd5);
        sb.push_back('{32'h1234_5678, start_cyc + 402, 1'b0});
        drive_frame(32'h1234_5678, 32'h0000_FFFF, 8'd20, 8'd5, -1);
        wait_quiet();

        // 3: repeat mode, stop during word 2
        do_start(1'b1, 32'hFFFF_FFFF, 8'd20, 8'd5);
        c = start_cyc;
        sb.push_back('{32'h1, c + 162, 1'b0});
        sb.push_back('{32'h2, c + 323, 1'b0});
        fork
            begin
                drive_frame(32'h1, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
                step();
                drive_frame(32'h2, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
                step();
                drive_frame(32'h3, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
            end
            begin
                repeat (240) step();
                stop_i = 1'b1;
                step();
                stop_i = 1'b0;
            end
        join
        wait_quiet();
        check("t3_busy_after_stop", {31'd0, busy_o}, 32'd0);
        check("t3_last_word", data_o, 32'h2);

        // 4: glitch on the last tick of bit 7, all slow
        do_start(1'b0, 32'h0000_0000, 8'd20, 8'd5);
        sb.push_back('{32'hC3C3_3C3C, start_cyc + 642, 1'b1});
        drive_frame(32'hC3C3_3C3C, 32'h0000_0000, 8'd20, 8'd5, 7);
        wait_quiet();
        repeat (5) step();
        check("t4_err_held", {31'd0, err_o}, 32'd1);

        // 5: start clears err, then reset during bit 10
        do_start(1'b0, 32'hFFFF_FFFF, 8'd20, 8'd5);
        check("t5_err_cleared_by_start", {31'd0, err_o}, 32'd0);
        fork
            drive_frame(32'h0F1E_2D3C, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
            begin
                repeat (52) step();
                rst_ni = 1'b0;
                step();
                check("t5_rst_data_o", data_o, 32'd0);
                check("t5_rst_flags", {27'd0, bit_tick_o, done_tick_o, busy_o, err_o, 1'b0}, 32'd0);
                step();
                rst_ni = 1'b1;
            end
        join
        repeat (5) step();
        check("t5_idle_after_abort", {31'd0, busy_o}, 32'd0);
        do_start(1'b0, 32'hFFFF_FFFF, 8'd20, 8'd5);
        sb.push_back('{32'hDEAD_BEEF, start_cyc + 162, 1'b0});
        drive_frame(32'hDEAD_BEEF, 32'hFFFF_FFFF, 8'd20, 8'd5, -1);
        wait_quiet();

        // 6: slow = 0 and fast = 1 both run as P = 1
        btick = 0;
        do_start(1'b0, 32'h0F0F_0F0F, 8'd0, 8'd1);
        sb.push_back('{32'h8421_7BDE, start_cyc + 34, 1'b0});
        drive_frame(32'h8421_7BDE, 32'h0F0F_0F0F, 8'd0, 8'd1, -1);
        wait_quiet();
        check("t6_bit_ticks", 32'(btick), 32'd32);

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
